// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: register offsets, CTRL bits, FSM states.
package irq_pkg;

  localparam logic [7:0] OffMask    = 8'd0;
  localparam logic [7:0] OffPending = 8'd1;
  localparam logic [7:0] OffActive  = 8'd2;
  localparam logic [7:0] OffCtrl    = 8'd3;
  localparam logic [7:0] OffCount   = 8'd4;

  localparam int unsigned CtrlEnBit = 0;
  localparam int unsigned CtrlRrBit = 1;

  localparam int unsigned HoldoffLen = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRaise,
    StAck,
    StHoldoff
  } irq_state_e;

endpackage

// File: rtl/irq_prio_select.sv
// Combinational rotating priority encoder: first set bit of eligible_i at or after the
// start index (wrapping), or from index 0 when round-robin is off.
module irq_prio_select
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] eligible_i,
  input  logic [2:0]         start_i,
  input  logic               rr_i,
  output logic [2:0]         id_o,
  output logic               found_o
);

  logic [7:0] elig8;
  assign elig8 = 8'(eligible_i);

  always_comb begin
    logic [3:0] idx;
    idx     = '0;
    id_o    = '0;
    found_o = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = (rr_i ? {1'b0, start_i} : 4'd0) + 4'(k);
      if (idx >= 4'(NUM_SRC)) idx = idx - 4'(NUM_SRC);
      if (!found_o && elig8[idx[2:0]]) begin
        found_o = 1'b1;
        id_o    = idx[2:0];
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Bus-mapped interrupt arbiter: latches source raises, masks, selects one winner for the CPU.
// Define IRQ_COUNT_EN to add per-source saturating service counters at BaseAddr+4+i.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 4,
  parameter logic [7:0]  BaseAddr = 8'hF0
) (
  input  logic               CLK,
  input  logic               RESET,
  inout  wire  [7:0]         BUS_DATA,
  input  logic [7:0]         BUS_ADDR,
  input  logic               BUS_WE,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  output logic [NUM_SRC-1:0] IRQ_ACK_OUT,
  output logic               CPU_INT_RAISE,
  input  logic               CPU_INT_ACK
);

`ifdef IRQ_COUNT_EN
  localparam logic [7:0] NumRegs = 8'(4 + NUM_SRC);
`else
  localparam logic [7:0] NumRegs = 8'd4;
`endif

  irq_state_e         state_q, state_d;
  logic               hold_cnt_q, hold_cnt_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               act_valid_q, act_valid_d;
  logic [2:0]         act_id_q, act_id_d;
  logic [2:0]         last_id_q, last_id_d;
  logic               rd_en_q;
  logic [7:0]         rd_data_q, rd_val;

  logic [7:0]         off;
  logic               in_range, wr_en, rd_req;
  logic [NUM_SRC-1:0] wdata_src, act_vec, suppress, eligible;
  logic [2:0]         rr_start, sel_id;
  logic               sel_found;

  assign off       = BUS_ADDR - BaseAddr;
  assign in_range  = off < NumRegs;
  assign wr_en     = BUS_WE & in_range;
  assign rd_req    = ~BUS_WE & in_range;
  assign wdata_src = BUS_DATA[NUM_SRC-1:0];
  assign BUS_DATA  = rd_en_q ? rd_data_q : 8'hzz;

  always_comb begin
    act_vec = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) act_vec[i] = (3'(i) == act_id_q);
  end

  assign eligible = pend_q & mask_q & {NUM_SRC{ctrl_q[CtrlEnBit]}};
  assign rr_start = (last_id_q == 3'(NUM_SRC - 1)) ? 3'd0 : last_id_q + 3'd1;

  irq_prio_select #(
    .NUM_SRC(NUM_SRC)
  ) u_prio_select (
    .eligible_i(eligible),
    .start_i   (rr_start),
    .rr_i      (ctrl_q[CtrlRrBit]),
    .id_o      (sel_id),
    .found_o   (sel_found)
  );

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    act_valid_d = act_valid_q;
    act_id_d    = act_id_q;
    last_id_d   = last_id_q;
    mask_d      = mask_q;
    ctrl_d      = ctrl_q;
    pend_d      = pend_q;

    if (wr_en) begin
      case (off)
        OffMask:    mask_d = wdata_src;
        OffPending: pend_d = pend_q & ~wdata_src;
        OffCtrl:    ctrl_d = BUS_DATA[1:0];
        default:    ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d     = StRaise;
          act_valid_d = 1'b1;
          act_id_d    = sel_id;
        end
      end
      StRaise: if (CPU_INT_ACK) state_d = StAck;
      StAck: begin
        pend_d     = pend_d & ~act_vec;
        last_id_d  = act_id_q;
        hold_cnt_d = 1'b0;
        state_d    = StHoldoff;
      end
      StHoldoff: begin
        if (hold_cnt_q == 1'(HoldoffLen - 1)) begin
          state_d     = StIdle;
          act_valid_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // The served source may still hold its line while it reacts to the ack pulse.
    suppress = (state_q == StAck || state_q == StHoldoff) ? act_vec : '0;
    pend_d   = pend_d | (IRQ_IN & ~suppress);
  end

  assign CPU_INT_RAISE = (state_q == StRaise);
  assign IRQ_ACK_OUT   = (state_q == StAck) ? act_vec : '0;

`ifdef IRQ_COUNT_EN
  logic [7:0] cnt_q [NUM_SRC];
  logic [7:0] cnt_d [NUM_SRC];

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (state_q == StAck && act_vec[i] && cnt_q[i] != 8'hFF) cnt_d[i] = cnt_q[i] + 8'd1;
      if (wr_en && off == OffCount + 8'(i)) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    case (off)
      OffMask:    rd_val = 8'(mask_q);
      OffPending: rd_val = 8'(pend_q);
      OffActive:  rd_val = {act_valid_q, 4'b0000, act_id_q};
      OffCtrl:    rd_val = {6'b000000, ctrl_q};
      default: begin
`ifdef IRQ_COUNT_EN
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (off == OffCount + 8'(i)) rd_val = cnt_q[i];
        end
`endif
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      hold_cnt_q  <= 1'b0;
      mask_q      <= '1;
      pend_q      <= '0;
      ctrl_q      <= 2'b01;
      act_valid_q <= 1'b0;
      act_id_q    <= '0;
      last_id_q   <= 3'(NUM_SRC - 1);
      rd_en_q     <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      ctrl_q      <= ctrl_d;
      act_valid_q <= act_valid_d;
      act_id_q    <= act_id_d;
      last_id_q   <= last_id_d;
      rd_en_q     <= rd_req;
      rd_data_q   <= rd_val;
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: register reads, fixed/round-robin service order, masking,
// no-preemption and async reset behaviour.
module tb_irq_arbiter;

  logic       clk;
  logic       rst;
  wire  [7:0] bus_data;
  logic [7:0] tb_drv;
  logic       tb_oe;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic [3:0] irq_in;
  logic [3:0] irq_ack_out;
  logic       cpu_int_raise;
  logic       cpu_int_ack;

  int n_checks = 0;
  int n_pass   = 0;

  assign bus_data = tb_oe ? tb_drv : 8'hzz;

  irq_arbiter #(
    .NUM_SRC (4),
    .BaseAddr(8'hF0)
  ) dut (
    .CLK          (clk),
    .RESET        (rst),
    .BUS_DATA     (bus_data),
    .BUS_ADDR     (bus_addr),
    .BUS_WE       (bus_we),
    .IRQ_IN       (irq_in),
    .IRQ_ACK_OUT  (irq_ack_out),
    .CPU_INT_RAISE(cpu_int_raise),
    .CPU_INT_ACK  (cpu_int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus_addr = addr;
    tb_drv   = data;
    tb_oe    = 1'b1;
    bus_we   = 1'b1;
    @(negedge clk);
    bus_we   = 1'b0;
    tb_oe    = 1'b0;
    bus_addr = 8'h00;
  endtask

  task automatic read_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    @(negedge clk);
    bus_addr = addr;
    bus_we   = 1'b0;
    @(negedge clk);
    d        = bus_data;
    bus_addr = 8'h00;
    check(tag, d, exp);
  endtask

  task automatic wait_raise(input string tag);
    int n = 0;
    while (!cpu_int_raise && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 8'(cpu_int_raise), 8'h01);
  endtask

  // CPU acks, source sees its pulse and drops its line, then the holdoff elapses.
  task automatic finish_service(input string tag, input int id);
    logic [3:0] exp_ack;
    exp_ack = 4'b0001 << id;
    @(negedge clk);
    cpu_int_ack = 1'b1;
    @(negedge clk);
    cpu_int_ack = 1'b0;
    check({tag, "_ack"}, 8'(irq_ack_out), 8'(exp_ack));
    irq_in[id] = 1'b0;
    @(negedge clk);
    check({tag, "_ack_end"}, 8'(irq_ack_out), 8'h00);
    repeat (3) @(negedge clk);
  endtask

  task automatic serve(input string tag, input int id);
    wait_raise({tag, "_raise"});
    read_check({tag, "_active"}, 8'hF2, 8'h80 | 8'(id));
    finish_service(tag, id);
  endtask

  initial begin
    rst         = 1'b1;
    tb_drv      = 8'h00;
    tb_oe       = 1'b0;
    bus_addr    = 8'h00;
    bus_we      = 1'b0;
    irq_in      = 4'b0000;
    cpu_int_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_raise", 8'(cpu_int_raise), 8'h00);
    check("rst_ack", 8'(irq_ack_out), 8'h00);
    read_check("rst_mask", 8'hF0, 8'h0F);
    read_check("rst_pend", 8'hF1, 8'h00);
    read_check("rst_active", 8'hF2, 8'h00);
    read_check("rst_ctrl", 8'hF3, 8'h01);

    // Single source: two-cycle latency, then ack routing.
    @(negedge clk);
    irq_in = 4'b0010;
    @(negedge clk);
    check("lat_early", 8'(cpu_int_raise), 8'h00);
    @(negedge clk);
    check("lat_raise", 8'(cpu_int_raise), 8'h01);
    read_check("single_active", 8'hF2, 8'h81);
    finish_service("single", 1);
    check("single_lowered", 8'(cpu_int_raise), 8'h00);
    read_check("single_pend", 8'hF1, 8'h00);

    // Fixed priority: lowest index first.
    irq_in = 4'b1010;
    serve("fix_a", 1);
    serve("fix_b", 3);

    // Round-robin with last_id=1: id3 before id0, then id1.
    bus_write(8'hF3, 8'h03);
    read_check("rr_ctrl", 8'hF3, 8'h03);
    irq_in = 4'b0010;
    serve("rr_pre", 1);
    irq_in = 4'b1011;
    serve("rr_a", 3);
    serve("rr_b", 0);
    serve("rr_c", 1);
    bus_write(8'hF3, 8'h01);

    // Masked source latches but never raises; W1C clears it.
    bus_write(8'hF0, 8'h0E);
    irq_in = 4'b0001;
    repeat (4) @(negedge clk);
    check("mask_noraise", 8'(cpu_int_raise), 8'h00);
    read_check("mask_pend", 8'hF1, 8'h01);
    irq_in = 4'b0000;
    bus_write(8'hF1, 8'h01);
    read_check("w1c_pend", 8'hF1, 8'h00);
    check("w1c_noraise", 8'(cpu_int_raise), 8'h00);
    bus_write(8'hF0, 8'h0F);

    // No preemption: disabling mid-service lets id2 finish; id0 waits for re-enable.
    irq_in = 4'b0100;
    wait_raise("np_raise");
    bus_write(8'hF3, 8'h00);
    irq_in[0] = 1'b1;
    check("np_still_raised", 8'(cpu_int_raise), 8'h01);
    finish_service("np", 2);
    repeat (3) @(negedge clk);
    check("np_disabled", 8'(cpu_int_raise), 8'h00);
    read_check("np_pend", 8'hF1, 8'h01);
    bus_write(8'hF3, 8'h01);
    serve("np_id0", 0);

    // Async reset during RAISE drops the request at once, no ack pulse follows.
    irq_in = 4'b0001;
    wait_raise("rst_mid_raise");
    @(negedge clk);
    rst         = 1'b1;
    cpu_int_ack = 1'b1;
    #1;
    check("rst_mid_async", 8'(cpu_int_raise), 8'h00);
    irq_in = 4'b0000;
    @(negedge clk);
    check("rst_mid_noack", 8'(irq_ack_out), 8'h00);
    cpu_int_ack = 1'b0;
    rst         = 1'b0;
    @(negedge clk);
    check("rst_mid_noack2", 8'(irq_ack_out), 8'h00);
    read_check("rst_mid_active", 8'hF2, 8'h00);
    read_check("rst_mid_pend", 8'hF1, 8'h00);

`ifdef IRQ_COUNT_EN
    for (int s = 0; s < 300; s++) begin
      irq_in = 4'b0001;
      wait_raise("cnt_raise");
      finish_service("cnt", 0);
    end
    read_check("cnt_sat", 8'hF4, 8'hFF);
    read_check("cnt_other", 8'hF5, 8'h00);
    bus_write(8'hF4, 8'h00);
    read_check("cnt_clear", 8'hF4, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
